// File: rtl/tcdm_read_streamer.sv
// Strided TCDM read initiator; returns read data as a valid/ready stream, with credit-based issue.
// Define TCDM_READ_STREAMER_PERF_EN to add the stall_cnt_o performance counter.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing requests (issued < len)
// DRAIN | all requests issued; waiting for responses and for the stream to empty
module tcdm_read_streamer #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned TCDMAddrWidth   = 12,
  parameter int unsigned LenWidth        = 16,
  parameter int unsigned FifoDepth       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [TCDMAddrWidth-1:0]     base_addr_i,
  input  logic [TCDMAddrWidth-1:0]     stride_i,
  input  logic [LenWidth-1:0]          len_i,
  output logic                         busy_o,
  output logic                         done_o,
`ifdef TCDM_READ_STREAMER_PERF_EN
  output logic [31:0]                  stall_cnt_o,
`endif
  output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
  output logic                         tcdm_req_write_o,
  output logic [3:0]                   tcdm_req_amo_o,
  output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
  output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
  output logic                         tcdm_req_q_valid_o,
  input  logic                         tcdm_rsp_q_ready_i,
  input  logic                         tcdm_rsp_p_valid_i,
  input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
  output logic [NarrowDataWidth-1:0]   data_o,
  output logic                         valid_o,
  input  logic                         ready_i
);

  localparam int unsigned OffW = $clog2(NarrowDataWidth/8);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = FifoDepth[CntW:0];

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [TCDMAddrWidth-1:0]   addr_q, addr_d;
  logic [TCDMAddrWidth-1:0]   stride_q, stride_d;
  logic [LenWidth-1:0]        len_q, len_d;
  logic [LenWidth-1:0]        issued_q, issued_d;
  logic [CntW-1:0]            out_q, out_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [PtrW-1:0]            wptr_q, wptr_d;
  logic [PtrW-1:0]            rptr_q, rptr_d;
  logic                       done_q, done_d;
  logic [NarrowDataWidth-1:0] mem_q [FifoDepth];

  logic credit_ok, req_valid, grant, push, pop;

  // Outstanding requests plus buffered words never exceed the FIFO depth, so every response has a slot.
  assign credit_ok = ({1'b0, out_q} + {1'b0, cnt_q}) < DepthC;
  assign req_valid = (state_q == RUN) && (issued_q < len_q) && credit_ok;
  assign grant     = req_valid && tcdm_rsp_q_ready_i;
  assign push      = tcdm_rsp_p_valid_i && (out_q != '0);
  assign pop       = (cnt_q != '0) && ready_i;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    out_d    = out_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d  = RUN;
            addr_d   = base_addr_i;
            stride_d = stride_i;
            len_d    = len_i;
            issued_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (grant) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + LenWidth'(1);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((out_q == '0) && (cnt_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({grant, push})
      2'b10:   out_d = out_q + CntW'(1);
      2'b01:   out_d = out_q - CntW'(1);
      default: out_d = out_q;
    endcase

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= tcdm_rsp_data_i;
  end

`ifdef TCDM_READ_STREAMER_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall;

  assign stall = (req_valid && !tcdm_rsp_q_ready_i) ||
                 ((state_q == RUN) && (issued_q < len_q) && !credit_ok);

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start_i)        stall_d = '0;
    else if (stall && (stall_q != '1))       stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign tcdm_req_addr_o    = {addr_q[TCDMAddrWidth-1:OffW], {OffW{1'b0}}};
  assign tcdm_req_write_o   = 1'b0;
  assign tcdm_req_amo_o     = '0;
  assign tcdm_req_data_o    = '0;
  assign tcdm_req_strb_o    = '1;
  assign tcdm_req_q_valid_o = req_valid;
  assign valid_o            = (cnt_q != '0);
  assign data_o             = valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_tcdm_read_streamer.sv
// Self-checking bench for tcdm_read_streamer: directed and random jobs against an address/data/credit model,
// with a bench-side TCDM memory that answers one cycle after each grant.
module tb_tcdm_read_streamer;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done;
  logic [AW-1:0] base, stride, req_addr;
  logic [LW-1:0] len;
  logic          req_write, q_valid, q_ready, p_valid, valid_out, ready;
  logic [3:0]    req_amo;
  logic [DW-1:0] req_data, rsp_data, data_out;
  logic [DW/8-1:0] req_strb;
`ifdef TCDM_READ_STREAMER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  logic rsp_auto_valid, rsp_force;
  assign p_valid = rsp_auto_valid | rsp_force;

  tcdm_read_streamer #(.NarrowDataWidth(DW), .TCDMAddrWidth(AW), .LenWidth(LW), .FifoDepth(FD)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .stride_i(stride), .len_i(len),
    .busy_o(busy), .done_o(done),
`ifdef TCDM_READ_STREAMER_PERF_EN
    .stall_cnt_o(stall_cnt),
`endif
    .tcdm_req_addr_o(req_addr), .tcdm_req_write_o(req_write), .tcdm_req_amo_o(req_amo),
    .tcdm_req_data_o(req_data), .tcdm_req_strb_o(req_strb), .tcdm_req_q_valid_o(q_valid),
    .tcdm_rsp_q_ready_i(q_ready), .tcdm_rsp_p_valid_i(p_valid), .tcdm_rsp_data_i(rsp_data),
    .data_o(data_out), .valid_o(valid_out), .ready_i(ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] mem [512];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation state, cleared by the main sequence before each job.
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            got_gcyc[$];
  int            pops = 0, done_cnt = 0, done_cyc = -1, busy_fall_cyc = -1, first_v_cyc = -1;
  int            cur_len = 0, stall_model = 0;
  logic          prev_hold = 1'b0, prev_rst = 1'b1, prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  always @(negedge clk) begin
    if (prev_hold && !prev_rst) begin
      check("hold_valid", q_valid, 1'b1);
      check("hold_addr", req_addr, prev_addr);
    end
    check("issue_rule", q_valid,
          busy && (got_addr.size() < cur_len) && ((got_addr.size() - pops) < FD));
    if (rst) stall_model = 0;
    else if (busy && (got_addr.size() < cur_len) && !(q_valid && q_ready)) stall_model++;
    if (q_valid && q_ready) begin
      got_addr.push_back(req_addr);
      got_gcyc.push_back(cyc);
      pend = 1'b1;
      pend_addr = req_addr;
    end else begin
      pend = 1'b0;
    end
    if (valid_out && (first_v_cyc < 0)) first_v_cyc = cyc;
    if (valid_out && ready) begin
      got_data.push_back(data_out);
      pops++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_busy && !busy && (busy_fall_cyc < 0)) busy_fall_cyc = cyc;
    prev_hold = q_valid && !q_ready;
    prev_addr = req_addr;
    prev_rst  = rst;
    prev_busy = busy;
  end

  // TCDM memory: answers exactly one cycle after each grant, garbage data otherwise.
  always @(posedge clk) begin
    #1;
    rsp_auto_valid = pend;
    rsp_data = pend ? mem[pend_addr[AW-1:3]] : {$urandom, $urandom};
  end

  task automatic clear_obs();
    got_addr.delete(); got_data.delete(); got_gcyc.delete();
    pops = 0; done_cnt = 0; done_cyc = -1; busy_fall_cyc = -1; first_v_cyc = -1; stall_model = 0;
  endtask

  task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n,
                         input int qr_pct, input int rd_pct, input int stall_n, input int bp_n,
                         input bit overlap, input bit chk_lat, input string tag);
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] a;
    int unsigned   sum;
    int            s_cyc;
    bit            fin;
    for (int i = 0; i < n; i++) begin
      sum = int'(b) + i * int'(s);
      a = AW'(sum % 4096);
      a[2:0] = 3'b000;
      exp_a.push_back(a);
      exp_d.push_back(mem[a[AW-1:3]]);
    end
    clear_obs();
    cur_len = n;
    @(posedge clk); #1;
    base = b; stride = s; len = LW'(n); start = 1'b1; q_ready = 1'b1; ready = 1'b1;
    s_cyc = cyc;
    fin = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start  = overlap && (c == 3);
      base   = AW'($urandom);
      stride = AW'($urandom);
      len    = LW'($urandom_range(1, 9));
      if ((bp_n > 0) && (c == bp_n)) begin
        check({tag, "_bp_grants"}, got_addr.size(), FD);
        check({tag, "_bp_qvalid"}, q_valid, 1'b0);
      end
      q_ready = (c < stall_n) ? 1'b0 : ($urandom_range(1, 100) <= qr_pct);
      ready   = (c < bp_n) ? 1'b0 : ($urandom_range(1, 100) <= rd_pct);
      if (done_cnt > 0) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0; q_ready = 1'b1; ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_finished"}, fin, 1'b1);
    check({tag, "_n_grants"}, got_addr.size(), n);
    check({tag, "_n_words"}, got_data.size(), n);
    for (int i = 0; (i < n) && (i < got_addr.size()); i++) check({tag, "_addr"}, got_addr[i], exp_a[i]);
    for (int i = 0; (i < n) && (i < got_data.size()); i++) check({tag, "_data"}, got_data[i], exp_d[i]);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_done_at_busy_fall"}, done_cyc, busy_fall_cyc);
    check({tag, "_idle_after"}, busy, 1'b0);
    if (chk_lat) begin
      for (int i = 0; (i < n) && (i < got_gcyc.size()); i++) check({tag, "_grant_cycle"}, got_gcyc[i], s_cyc + 1 + i);
      check({tag, "_first_data_cycle"}, first_v_cyc, s_cyc + 3);
    end
`ifdef TCDM_READ_STREAMER_PERF_EN
    check({tag, "_stall_cnt"}, stall_cnt, stall_model);
    if (stall_n > 0) check({tag, "_stall_cnt_exact"}, stall_cnt, stall_n);
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; base = '0; stride = '0; len = '0;
    q_ready = 1'b1; ready = 1'b1; rsp_force = 1'b0; rsp_auto_valid = 1'b0; rsp_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_qvalid", q_valid, 1'b0);
    check("rst_addr", req_addr, '0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, '0);
    check("rst_write", req_write, 1'b0);
    check("rst_amo", req_amo, '0);
    check("rst_wdata", req_data, '0);
    check("rst_strb", req_strb, 8'hFF);
`ifdef TCDM_READ_STREAMER_PERF_EN
    check("rst_stall_cnt", stall_cnt, '0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(12'h000, 12'h008, 4, 100, 100, 0, 0, 1'b0, 1'b1, "seq");
    run_job(12'h040, 12'h008, 8, 100, 100, 0, 15, 1'b0, 1'b0, "backpressure");
    run_job(12'h100, 12'h008, 2, 100, 100, 5, 0, 1'b0, 1'b0, "grant_stall");
    run_job(12'hFF8, 12'h008, 2, 100, 100, 0, 0, 1'b0, 1'b1, "wrap");
    run_job(12'h300, 12'h010, 6, 100, 100, 0, 0, 1'b1, 1'b0, "overlap");

    // Zero-length job: done_o the next cycle, no requests.
    clear_obs();
    cur_len = 0;
    @(posedge clk); #1;
    start = 1'b1; len = '0; base = 12'h123;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_qvalid", q_valid, 1'b0);
`ifdef TCDM_READ_STREAMER_PERF_EN
    check("zero_stall_cleared", stall_cnt, '0);
`endif
    @(negedge clk);
    check("zero_done_pulse", done, 1'b0);
    repeat (3) @(negedge clk);
    check("zero_no_grants", got_addr.size(), 0);
    check("zero_done_once", done_cnt, 1);

    for (int j = 0; j < 6; j++)
      run_job(AW'($urandom), AW'($urandom), $urandom_range(1, 16),
              $urandom_range(50, 100), $urandom_range(30, 100), 0, 0, 1'b0, 1'b0, "random");

    // Mid-job reset after two grants; a late response must not create a stream word.
    clear_obs();
    cur_len = 6;
    @(posedge clk); #1;
    base = 12'h080; stride = 12'h008; len = LW'(6); start = 1'b1; q_ready = 1'b1; ready = 1'b0;
    begin : wait_two
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (got_addr.size() >= 2) disable wait_two;
      end
    end
    check("mid_rst_two_grants", got_addr.size(), 2);
    rst = 1'b1; q_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", valid_out, 1'b0);
    check("mid_rst_qvalid", q_valid, 1'b0);
`ifdef TCDM_READ_STREAMER_PERF_EN
    check("mid_rst_stall_cnt", stall_cnt, '0);
`endif
    @(posedge clk); #1;
    rsp_force = 1'b1;
    @(posedge clk); #1;
    rsp_force = 1'b0;
    @(negedge clk);
    check("stale_rsp_ignored", valid_out, 1'b0);
    repeat (2) @(negedge clk);
    check("stale_rsp_still_empty", valid_out, 1'b0);
    check("mid_rst_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
